// File: rtl/miniled_frame_scheduler.sv
// Double-buffered per-zone brightness scheduler: shadow bank is committed to the
// active bank on a driver frame boundary, with forced blanking after mode changes.
module miniled_frame_scheduler #(
    parameter int unsigned ZONES        = 9,
    parameter int unsigned DW           = 8,
    parameter int unsigned BLANK_FRAMES = 2
) (
    input  logic                  I_clk,
    input  logic                  I_rst_n,
    input  logic                  I_wr_valid,
    output logic                  O_wr_ready,
    input  logic [3:0]            I_wr_addr,
    input  logic [DW-1:0]         I_wr_data,
    input  logic                  I_commit,
    output logic                  O_commit_pending,
    input  logic                  I_frame_sync,
    input  logic [1:0]            I_led_mode,
    output logic [ZONES*DW-1:0]   O_led_light,
    output logic                  O_swap,
    output logic                  O_blank,
    output logic                  O_err_addr
);

    localparam int unsigned LW = ZONES * DW;

    typedef enum logic {
        FILL    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t        state_q;
    logic [LW-1:0] shadow_q;
    logic [LW-1:0] active_q;
    logic [1:0]    mode_q;
    logic [3:0]    blank_cnt_q;
    logic          swap_q;
    logic          err_q;

    logic          wr_acc_c;
    logic          addr_ok_c;

    assign wr_acc_c  = I_wr_valid && (state_q == FILL);
    assign addr_ok_c = ({1'b0, I_wr_addr} < 5'(ZONES));

    // Commit/swap FSM, shadow/active banks and blanking counter
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q     <= FILL;
            shadow_q    <= '0;
            active_q    <= '0;
            mode_q      <= 2'b00;
            blank_cnt_q <= 4'd0;
            swap_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            swap_q <= 1'b0;
            err_q  <= 1'b0;

            case (state_q)
                FILL: begin
                    if (wr_acc_c) begin
                        if (addr_ok_c) begin
                            for (int unsigned k = 0; k < ZONES; k++) begin
                                if (I_wr_addr == 4'(k)) begin
                                    shadow_q[k*DW +: DW] <= I_wr_data;
                                end
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    if (I_commit) begin
                        state_q <= PENDING;
                    end
                end
                PENDING: begin
                    if (I_frame_sync) begin
                        active_q <= shadow_q;
                        swap_q   <= 1'b1;
                        state_q  <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase

            // A mode change reloads the count even if a frame_sync coincides
            mode_q <= I_led_mode;
            if (I_led_mode != mode_q) begin
                blank_cnt_q <= 4'(BLANK_FRAMES);
            end else if (I_frame_sync && (blank_cnt_q != 4'd0)) begin
                blank_cnt_q <= blank_cnt_q - 4'd1;
            end
        end
    end

    assign O_wr_ready       = (state_q == FILL);
    assign O_commit_pending = (state_q == PENDING);
    assign O_swap           = swap_q;
    assign O_err_addr       = err_q;
    assign O_blank          = (blank_cnt_q != 4'd0);
    assign O_led_light      = O_blank ? '0 : active_q;

endmodule

// File: tb/tb_miniled_frame_scheduler.sv
// Randomized + directed bench for miniled_frame_scheduler against a zone-array model.
module tb_miniled_frame_scheduler;

    localparam int unsigned ZONES = 9;
    localparam int unsigned DW    = 8;
    localparam int unsigned BF    = 2;
    localparam int unsigned LW    = ZONES * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [3:0]    wr_addr = 4'd0;
    logic [DW-1:0] wr_data = '0;
    logic          commit = 1'b0;
    logic          commit_pending;
    logic          frame_sync = 1'b0;
    logic [1:0]    led_mode = 2'b00;
    logic [LW-1:0] led_light;
    logic          swap;
    logic          blank;
    logic          err_addr;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int unsigned m_shadow [ZONES];
    int unsigned m_active [ZONES];
    bit          m_pend;
    int unsigned m_mode;
    int          m_blank;
    bit          m_swap;
    bit          m_err;

    always #10 clk = ~clk;

    miniled_frame_scheduler #(.ZONES(ZONES), .DW(DW), .BLANK_FRAMES(BF)) dut (
        .I_clk            (clk),
        .I_rst_n          (rst_n),
        .I_wr_valid       (wr_valid),
        .O_wr_ready       (wr_ready),
        .I_wr_addr        (wr_addr),
        .I_wr_data        (wr_data),
        .I_commit         (commit),
        .O_commit_pending (commit_pending),
        .I_frame_sync     (frame_sync),
        .I_led_mode       (led_mode),
        .O_led_light      (led_light),
        .O_swap           (swap),
        .O_blank          (blank),
        .O_err_addr       (err_addr)
    );

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < ZONES; k++) begin
            m_shadow[k] = 0;
            m_active[k] = 0;
        end
        m_pend  = 0;
        m_mode  = 0;
        m_blank = 0;
        m_swap  = 0;
        m_err   = 0;
    endtask

    function automatic logic [LW-1:0] model_light();
        logic [LW-1:0] v = '0;
        if (m_blank == 0) begin
            for (int k = 0; k < ZONES; k++) v[k*DW +: DW] = DW'(m_active[k]);
        end
        return v;
    endfunction

    task automatic compare_all();
        check("wr_ready",       LW'(wr_ready),       LW'(!m_pend));
        check("commit_pending", LW'(commit_pending), LW'(m_pend));
        check("swap",           LW'(swap),           LW'(m_swap));
        check("blank",          LW'(blank),          LW'(m_blank != 0));
        check("err_addr",       LW'(err_addr),       LW'(m_err));
        check("led_light",      led_light,           model_light());
    endtask

    // Apply inputs for one clock, advance the model with the spec rules, then compare.
    task automatic cyc(input bit v, input int unsigned a, input int unsigned d,
                       input bit c, input bit s, input int unsigned mode);
        wr_valid   = v;
        wr_addr    = 4'(a);
        wr_data    = DW'(d);
        commit     = c;
        frame_sync = s;
        led_mode   = 2'(mode);
        @(posedge clk);
        m_swap = 0;
        m_err  = 0;
        if (!m_pend) begin
            if (v) begin
                if (a < ZONES) m_shadow[a] = d & 8'hFF;
                else m_err = 1;
            end
            if (c) m_pend = 1;
        end else if (s) begin
            m_active = m_shadow;
            m_swap   = 1;
            m_pend   = 0;
        end
        if (mode != m_mode) m_blank = BF;
        else if (s && m_blank > 0) m_blank--;
        m_mode = mode;
        #1;
        compare_all();
    endtask

    task automatic idle(input int unsigned mode);
        cyc(0, 0, 0, 0, 0, mode);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        compare_all();
        check("reset_light_lit", led_light, '0);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [LW-1:0] bank1;
        logic [LW-1:0] bank2;
        int unsigned   mode;
        bank1 = 72'h18_17_16_15_14_13_12_11_10;
        bank2 = 72'h18_17_16_15_14_AA_12_11_10;
        model_reset();
        #5;
        compare_all();
        check("reset_ready_lit", LW'(wr_ready), LW'(1));
        #20;
        rst_n = 1'b1;

        // Fill all zones and commit; nothing visible without a sync
        for (int k = 0; k < ZONES; k++) cyc(1, k, 8'h10 + k, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 100; i++) idle(0);
        check("hold_light_lit", led_light, '0);
        check("hold_pending_lit", LW'(commit_pending), LW'(1));
        cyc(0, 0, 0, 0, 1, 0);
        check("swap_light_lit", led_light, bank1);
        check("swap_pulse_lit", LW'(swap), LW'(1));
        idle(0);
        check("swap_once_lit", LW'(swap), LW'(0));

        // Out-of-range zone is dropped
        cyc(1, 9, 8'hFF, 0, 0, 0);
        check("err_pulse_lit", LW'(err_addr), LW'(1));
        idle(0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        check("err_bank_lit", led_light, bank1);

        // Write lands in the same cycle as the commit
        cyc(1, 3, 8'hAA, 1, 0, 0);
        idle(0);
        cyc(0, 0, 0, 0, 1, 0);
        check("wc_bank_lit", led_light, bank2);

        // Mode change blanking, then reload on coincident sync
        cyc(0, 0, 0, 0, 0, 2);
        check("blank_on_lit", LW'(blank), LW'(1));
        check("blank_light_lit", led_light, '0);
        cyc(0, 0, 0, 0, 1, 2);
        check("blank_1sync_lit", led_light, '0);
        idle(2);
        cyc(0, 0, 0, 0, 1, 2);
        check("blank_end_lit", led_light, bank2);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 3);
        cyc(0, 0, 0, 0, 1, 3);
        check("reload_still_blank_lit", LW'(blank), LW'(1));
        cyc(0, 0, 0, 0, 1, 3);
        check("reload_end_lit", led_light, bank2);

        // Reset while pending suppresses the swap
        cyc(1, 0, 8'h55, 1, 0, 3);
        check("rst_pre_pending_lit", LW'(commit_pending), LW'(1));
        async_reset();
        cyc(0, 0, 0, 0, 1, 0);
        check("rst_no_swap_lit", LW'(swap), LW'(0));
        check("rst_light_lit", led_light, '0);

        // Randomized traffic
        mode = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) mode = $urandom_range(0, 3);
            cyc($urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15)
                                                                  : $urandom_range(0, ZONES - 1),
                $urandom_range(0, 255), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) == 0), mode);
            if ($urandom_range(0, 599) == 0) begin
                async_reset();
                mode = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
